// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet FIFO: mode encodings and
// address-width derivation.
package axis_pkg;
   localparam int AXIS_MODE_CUT = 0;
   localparam int AXIS_MODE_PKT = 1;

   function automatic int axis_addr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Each word carries tlast in its top bit.
module axis_fifo_ram #(
   parameter int WIDTH  = 33,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with FWFT output, beat/packet occupancy counters and an
// optional store-and-forward mode that holds beats back until tlast is stored.
module axis_packet_fifo
   import axis_pkg::*;
#(
   parameter  int DATA_WIDTH  = 32,
   parameter  int DEPTH       = 16,
   parameter  int PACKET_MODE = AXIS_MODE_CUT,
   localparam int ADDR_W      = axis_addr_w(DEPTH)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [ADDR_W:0]       data_count,
   output logic [ADDR_W:0]       pkt_count
);
   localparam logic [ADDR_W:0] CNT_ONE  = 1;
   localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0]     wr_ptr, rd_ptr, dc_nxt, pc_nxt;
   logic [DATA_WIDTH:0] rdata;
   logic                s_rdy, rel, rel_nxt;
   logic                wr_en, rd_en, wr_last, rd_last, head_tlast, m_vld;

   axis_fifo_ram #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (aclk),
      .we   (wr_en),
      .waddr(wr_ptr[ADDR_W-1:0]),
      .wdata({s_axis_tlast, s_axis_tdata}),
      .raddr(rd_ptr[ADDR_W-1:0]),
      .rdata(rdata)
   );

   assign head_tlast = rdata[DATA_WIDTH];
   // In packet mode a beat is only visible once a whole packet is stored, or
   // once the oversize release lets a packet bigger than the FIFO through.
   assign m_vld   = (data_count != '0) &
                    ((PACKET_MODE == AXIS_MODE_CUT) | (pkt_count != '0) | rel);
   assign wr_en   = s_axis_tvalid & s_rdy;
   assign rd_en   = m_vld & m_axis_tready;
   assign wr_last = wr_en & s_axis_tlast;
   assign rd_last = rd_en & head_tlast;

   assign s_axis_tready = s_rdy;
   assign m_axis_tvalid = m_vld;
   assign m_axis_tlast  = m_vld & head_tlast;
   assign m_axis_tdata  = m_vld ? rdata[DATA_WIDTH-1:0] : '0;

   always_comb begin
      dc_nxt  = data_count;
      pc_nxt  = pkt_count;
      rel_nxt = rel;
      if (wr_en && !rd_en)      dc_nxt = data_count + CNT_ONE;
      else if (!wr_en && rd_en) dc_nxt = data_count - CNT_ONE;
      if (wr_last && !rd_last)      pc_nxt = pkt_count + CNT_ONE;
      else if (!wr_last && rd_last) pc_nxt = pkt_count - CNT_ONE;
      if (PACKET_MODE != AXIS_MODE_PKT)                  rel_nxt = 1'b0;
      else if (rd_last)                                  rel_nxt = 1'b0;
      else if (data_count == CNT_FULL && pkt_count == '0) rel_nxt = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         pkt_count  <= '0;
         s_rdy      <= 1'b0;
         rel        <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + CNT_ONE;
         if (rd_en) rd_ptr <= rd_ptr + CNT_ONE;
         data_count <= dc_nxt;
         pkt_count  <= pc_nxt;
         // Ready is judged on the next-state count so a read frees the slot.
         s_rdy      <= (dc_nxt != CNT_FULL);
         rel        <= rel_nxt;
      end
   end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench: a cut-through and a store-and-forward instance share one
// input stimulus; each test checks whichever instance it targets.
module tb_axis_packet_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;

   logic          c_s_tready, c_m_tlast, c_m_tvalid;
   logic [DW-1:0] c_m_tdata;
   logic [4:0]    c_dcnt, c_pcnt;
   logic          p_s_tready, p_m_tlast, p_m_tvalid;
   logic [DW-1:0] p_m_tdata;
   logic [4:0]    p_dcnt, p_pcnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 aclk = ~aclk;

   axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_cut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(c_s_tready),
      .m_axis_tdata(c_m_tdata), .m_axis_tlast(c_m_tlast), .m_axis_tvalid(c_m_tvalid),
      .m_axis_tready(m_tready),
      .data_count(c_dcnt), .pkt_count(c_pcnt)
   );

   axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pkt (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(p_s_tready),
      .m_axis_tdata(p_m_tdata), .m_axis_tlast(p_m_tlast), .m_axis_tvalid(p_m_tvalid),
      .m_axis_tready(m_tready),
      .data_count(p_dcnt), .pkt_count(p_pcnt)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic l);
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      aresetn  = 1'b0;
      cyc();
      aresetn  = 1'b1;
      cyc();
   endtask

   // Push n beats base.. into the packet-mode instance and check what leaves it.
   task automatic xfer(input logic [DW-1:0] base, input int n, input bit oversize);
      int   snd = 0;
      int   rcv = 0;
      bit   first = 1'b1;
      bit   acc;
      logic [DW:0] exp_beat;
      drive(base, n == 1);
      for (int k = 0; k < 300 && rcv < n; k++) begin
         acc = s_tvalid && p_s_tready;
         if (p_m_tvalid) begin
            if (first && oversize) begin
               chk("rel_pkt_cnt", p_pcnt, 0);
               chk("rel_data_cnt", p_dcnt, DEPTH);
            end
            first    = 1'b0;
            exp_beat = {(rcv == n - 1), base + DW'(rcv)};
            chk($sformatf("pkt_beat%0d", rcv), {p_m_tlast, p_m_tdata}, exp_beat);
            rcv++;
         end
         cyc();
         if (acc) snd++;
         if (snd < n) drive(base + DW'(snd), snd == n - 1);
         else s_tvalid = 1'b0;
      end
      chk("pkt_beats_out", rcv, n);
      s_tvalid = 1'b0;
      cyc();
      chk("pkt_drain_vld", p_m_tvalid, 0);
      chk("pkt_drain_dcnt", p_dcnt, 0);
      chk("pkt_drain_pcnt", p_pcnt, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      // Reset state and registered tready rise
      cyc();
      cyc();
      chk("rst_c_s_tready", c_s_tready, 0);
      chk("rst_c_m_tvalid", c_m_tvalid, 0);
      chk("rst_c_m_tlast", c_m_tlast, 0);
      chk("rst_c_dcnt", c_dcnt, 0);
      chk("rst_c_pcnt", c_pcnt, 0);
      chk("rst_p_s_tready", p_s_tready, 0);
      chk("rst_p_m_tvalid", p_m_tvalid, 0);
      aresetn = 1'b1;
      #1;
      chk("rel_tready_pre_edge", c_s_tready, 0);
      cyc();
      chk("rel_tready_post_edge", c_s_tready, 1);

      // Cut-through streaming, each beat visible one cycle after input
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(DW'(i), i == 15);
         cyc();
         chk($sformatf("cut_beat%0d", i), {c_m_tvalid, c_m_tlast, c_m_tdata},
             {1'b1, (i == 15), DW'(i)});
      end
      s_tvalid = 1'b0;
      cyc();
      chk("cut_end_vld", c_m_tvalid, 0);
      chk("cut_end_dcnt", c_dcnt, 0);
      chk("cut_end_pcnt", c_pcnt, 0);

      // Fill to DEPTH, then one read frees a slot and traffic flows 1-in/1-out
      do_reset();
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(DW'(32'h20 + i), 1'b0);
         cyc();
      end
      s_tvalid = 1'b0;
      chk("full_tready", c_s_tready, 0);
      chk("full_dcnt", c_dcnt, 16);
      chk("full_head", c_m_tdata, 32'h20);
      m_tready = 1'b1;
      drive(32'h40, 1'b0);
      cyc();
      chk("full_rd_dcnt", c_dcnt, 15);
      chk("full_rd_tready", c_s_tready, 1);
      chk("full_rd_head", c_m_tdata, 32'h21);
      for (int k = 0; k < 4; k++) begin
         drive(DW'(32'h40 + k), 1'b0);
         cyc();
         chk($sformatf("flow_dcnt%0d", k), c_dcnt, 15);
         chk($sformatf("flow_head%0d", k), c_m_tdata, 32'h22 + k);
         chk($sformatf("flow_tready%0d", k), c_s_tready, 1);
      end
      s_tvalid = 1'b0;

      // Store-and-forward: nothing visible until tlast stored
      do_reset();
      m_tready = 1'b1;
      drive(32'hA, 1'b0); cyc(); chk("pkt_hold_a", p_m_tvalid, 0);
      drive(32'hB, 1'b0); cyc(); chk("pkt_hold_b", p_m_tvalid, 0);
      drive(32'hC, 1'b0); cyc(); chk("pkt_hold_c", p_m_tvalid, 0);
      s_tvalid = 1'b0;
      cyc(); chk("pkt_hold_gap1", p_m_tvalid, 0);
      cyc(); chk("pkt_hold_gap2", p_m_tvalid, 0);
      drive(32'hD, 1'b1);
      cyc();
      s_tvalid = 1'b0;
      chk("pkt_out_a", {p_m_tvalid, p_m_tlast, p_m_tdata}, {2'b10, 32'hA});
      chk("pkt_cnt_1", p_pcnt, 1);
      cyc(); chk("pkt_out_b", {p_m_tvalid, p_m_tlast, p_m_tdata}, {2'b10, 32'hB});
      cyc(); chk("pkt_out_c", {p_m_tvalid, p_m_tlast, p_m_tdata}, {2'b10, 32'hC});
      cyc(); chk("pkt_out_d", {p_m_tvalid, p_m_tlast, p_m_tdata}, {2'b11, 32'hD});
      chk("pkt_cnt_still_1", p_pcnt, 1);
      cyc();
      chk("pkt_done_vld", p_m_tvalid, 0);
      chk("pkt_cnt_0", p_pcnt, 0);

      // Oversize packet forces release, then release must not linger
      do_reset();
      m_tready = 1'b1;
      xfer(32'h200, 20, 1'b1);
      drive(32'h3FF, 1'b0);
      cyc();
      s_tvalid = 1'b0;
      cyc();
      chk("rel_cleared", p_m_tvalid, 0);
      chk("rel_cleared_dcnt", p_dcnt, 1);

      // Reset mid-packet discards contents; next packet emerges intact
      do_reset();
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(DW'(32'h300 + i), 1'b0);
         cyc();
      end
      chk("mid_c_dcnt", c_dcnt, 5);
      chk("mid_p_dcnt", p_dcnt, 5);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_c_dcnt", c_dcnt, 0);
      chk("mid_rst_c_vld", c_m_tvalid, 0);
      chk("mid_rst_p_dcnt", p_dcnt, 0);
      chk("mid_rst_p_vld", p_m_tvalid, 0);
      s_tvalid = 1'b0;
      cyc();
      aresetn = 1'b1;
      cyc();
      m_tready = 1'b1;
      xfer(32'h100, 4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
